// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with coordinate request, delay-aligned
// colour output stage and built-in test patterns.
module vga_timing_gen #(
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 200,
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 64,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 24,
    parameter int V_ACTIVE  = 800,
    parameter int V_FP      = 1,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b1,
    parameter int COLOR_W   = 4,
    parameter int PIPE_DLY  = 1,
    parameter int X_W       = 11,
    parameter int Y_W       = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] r_in,
    input  logic [COLOR_W-1:0] g_in,
    input  logic [COLOR_W-1:0] b_in,
    output logic [X_W-1:0]     curr_x,
    output logic [Y_W-1:0]     curr_y,
    output logic               req_valid,
    output logic [COLOR_W-1:0] pix_r,
    output logic [COLOR_W-1:0] pix_g,
    output logic [COLOR_W-1:0] pix_b,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HS    = H_SYNC + H_BP;
    localparam int VS    = V_SYNC + V_BP;

    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOT - 1);
    localparam logic [X_W-1:0] HS_X     = X_W'(HS);
    localparam logic [X_W-1:0] HE_X     = X_W'(HS + H_ACTIVE);
    localparam logic [X_W-1:0] HSYNC_X  = X_W'(H_SYNC);
    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOT - 1);
    localparam logic [Y_W-1:0] VS_Y     = Y_W'(VS);
    localparam logic [Y_W-1:0] VE_Y     = Y_W'(VS + V_ACTIVE);
    localparam logic [Y_W-1:0] VSYNC_Y  = Y_W'(V_SYNC);

    typedef struct packed {
        logic           vld;
        logic           hs;
        logic           vs;
        logic           x0;
        logic           xy0;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } stage_t;

    // Bar index 8*x/H_ACTIVE as a count of crossed thresholds, avoiding a divider.
    function automatic logic [2:0] bar_index(input logic [X_W-1:0] x);
        logic [X_W+2:0] x8;
        logic [2:0]     idx;
        x8  = {x, 3'b000};
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x8 >= (X_W+3)'(k * H_ACTIVE)) idx = idx + 3'd1;
        end
        return idx;
    endfunction

    logic [X_W-1:0]     hcount;
    logic [Y_W-1:0]     vcount;
    stage_t             st_nx;
    stage_t             pipe_p [0:PIPE_DLY];
    stage_t             od;
    logic [2:0]         bar_i;
    logic [COLOR_W-1:0] r_nx, g_nx, b_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (en) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + Y_W'(1);
            end else begin
                hcount <= hcount + X_W'(1);
            end
        end
    end

    always_comb begin
        st_nx     = '0;
        st_nx.vld = (hcount >= HS_X) && (hcount < HE_X) && (vcount >= VS_Y) && (vcount < VE_Y);
        st_nx.hs  = hcount < HSYNC_X;
        st_nx.vs  = vcount < VSYNC_Y;
        if (st_nx.vld) begin
            st_nx.x = hcount - HS_X;
            st_nx.y = vcount - VS_Y;
        end
        st_nx.x0  = (st_nx.x == '0);
        st_nx.xy0 = st_nx.x0 && (st_nx.y == '0);
    end

    // Stage 0 (coordinate request) and the PIPE_DLY-deep alignment delay line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= PIPE_DLY; k++) pipe_p[k] <= '0;
        end else if (en) begin
            pipe_p[0] <= st_nx;
            for (int k = PIPE_DLY; k >= 1; k--) pipe_p[k] <= pipe_p[k-1];
        end
    end

    assign curr_x    = pipe_p[0].x;
    assign curr_y    = pipe_p[0].y;
    assign req_valid = pipe_p[0].vld;
    assign od        = pipe_p[PIPE_DLY];
    assign bar_i     = bar_index(od.x);

    always_comb begin
        r_nx = '0;
        g_nx = '0;
        b_nx = '0;
        if (od.vld) begin
            case (mode)
                2'd0: begin
                    r_nx = r_in;
                    g_nx = g_in;
                    b_nx = b_in;
                end
                2'd1: begin
                    r_nx = {COLOR_W{bar_i[0]}};
                    g_nx = {COLOR_W{bar_i[1]}};
                    b_nx = {COLOR_W{bar_i[2]}};
                end
                2'd2: begin
                    r_nx = {COLOR_W{od.x[5] ^ od.y[5]}};
                    g_nx = {COLOR_W{od.x[5] ^ od.y[5]}};
                    b_nx = {COLOR_W{od.x[5] ^ od.y[5]}};
                end
                default: ;
            endcase
        end
    end

    // Output stage: colour, data enable, sync levels and frame markers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
            de          <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            pix_r       <= r_nx;
            pix_g       <= g_nx;
            pix_b       <= b_nx;
            de          <= od.vld;
            hsync       <= od.hs ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= od.vs ? VSYNC_POL : ~VSYNC_POL;
            line_start  <= od.vld && od.x0;
            frame_start <= od.vld && od.xy0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster (76x45 totals, PIPE_DLY=2).
module tb_vga_timing_gen;

    localparam int HSY = 4, HBP = 4, HA = 64, HFP = 4;
    localparam int VSY = 2, VBP = 2, VA = 40, VFP = 1;
    localparam int P = 2;
    localparam int HT = HSY + HBP + HA + HFP;
    localparam int VT = VSY + VBP + VA + VFP;
    localparam int HS = HSY + HBP;
    localparam int VS = VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int NOPE = 10000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
    logic [10:0] curr_x;
    logic [9:0]  curr_y;
    logic        req_valid;
    logic [3:0]  pix_r, pix_g, pix_b;
    logic        hsync, vsync, de, line_start, frame_start;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_SYNC(HSY), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
        .V_SYNC(VSY), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .COLOR_W(4), .PIPE_DLY(P),
        .X_W(11), .Y_W(10)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .curr_x(curr_x), .curr_y(curr_y), .req_valid(req_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .hsync(hsync), .vsync(vsync), .de(de),
        .line_start(line_start), .frame_start(frame_start)
    );

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       de;
        logic       ls;
        logic       fs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } out_t;

    typedef struct packed {
        logic        vld;
        logic [10:0] x;
        logic [9:0]  y;
    } req_t;

    typedef struct {
        logic [1:0]  md;
        int          x;
        int          y;
        logic [11:0] rgb;
    } spot_t;

    typedef struct {
        logic       en;
        logic [1:0] md;
        int         n;
    } phase_t;

    int     checks = 0;
    int     errors = 0;
    int     qh[$];
    int     qv[$];
    int     m_hc, m_vc;
    out_t   last_o;
    req_t   last_q;
    int     fs_cnt, ls_cnt, de_cnt;
    spot_t  sp[16];
    bit     hit[16];
    phase_t ph[7];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic act(input int hc, input int vc);
        return hc >= HS && hc < HS + HA && vc >= VS && vc < VS + VA;
    endfunction

    function automatic out_t model_out(input int hc, input int vc, input logic [1:0] md);
        out_t       o;
        int         x, y;
        logic [2:0] bar;
        logic [3:0] c;
        o = '0;
        x = hc - HS;
        y = vc - VS;
        o.hsync = (hc < HSY) ? 1'b0 : 1'b1;
        o.vsync = (vc < VSY) ? 1'b1 : 1'b0;
        if (act(hc, vc)) begin
            o.de = 1'b1;
            o.ls = (x == 0);
            o.fs = (x == 0) && (y == 0);
            case (md)
                2'd0: begin
                    o.r = 4'(x);
                    o.g = 4'(y);
                    o.b = 4'(x + y);
                end
                2'd1: begin
                    bar = 3'((8 * x) / HA);
                    o.r = {4{bar[0]}};
                    o.g = {4{bar[1]}};
                    o.b = {4{bar[2]}};
                end
                2'd2: begin
                    c = (((x / 32) % 2) != ((y / 32) % 2)) ? 4'hF : 4'h0;
                    o.r = c;
                    o.g = c;
                    o.b = c;
                end
                default: ;
            endcase
        end
        return o;
    endfunction

    function automatic req_t model_req(input int hc, input int vc);
        req_t q;
        q = '0;
        if (act(hc, vc)) begin
            q.vld = 1'b1;
            q.x   = 11'(hc - HS);
            q.y   = 10'(vc - VS);
        end
        return q;
    endfunction

    task automatic spot(input int hc, input int vc, input logic [1:0] md);
        if (act(hc, vc)) begin
            for (int i = 0; i < 16; i++) begin
                if (sp[i].md == md && sp[i].x == hc - HS && sp[i].y == vc - VS) begin
                    chk("spot_rgb", 32'({pix_r, pix_g, pix_b}), 32'(sp[i].rgb));
                    hit[i] = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, then score outputs.
    task automatic step(input logic e, input logic [1:0] md);
        out_t eo, go;
        req_t eq, gq;
        int   fh, fv;
        en   = e;
        mode = md;
        if (act(qh[0], qv[0])) begin
            r_in = 4'(qh[0] - HS);
            g_in = 4'(qv[0] - VS);
            b_in = 4'(qh[0] - HS + qv[0] - VS);
        end else begin
            {r_in, g_in, b_in} = 12'($urandom);
        end
        if (e) begin
            qh.push_back(m_hc);
            qv.push_back(m_vc);
        end
        @(posedge clk);
        #1;
        if (e) begin
            eq = model_req(m_hc, m_vc);
            fh = qh.pop_front();
            fv = qv.pop_front();
            eo = model_out(fh, fv, md);
            spot(fh, fv, md);
            m_hc++;
            if (m_hc == HT) begin
                m_hc = 0;
                m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
            end
            last_o = eo;
            last_q = eq;
        end else begin
            eo = last_o;
            eq = last_q;
        end
        go = {hsync, vsync, de, line_start, frame_start, pix_r, pix_g, pix_b};
        gq = {req_valid, curr_x, curr_y};
        chk("out", 32'(go), 32'(eo));
        chk("req", 32'(gq), 32'(eq));
        fs_cnt += int'(frame_start);
        ls_cnt += int'(line_start);
        de_cnt += int'(de);
    endtask

    // Asserts reset between clock edges and checks it takes effect without a clock.
    task automatic apply_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_out", 32'({hsync, vsync, de, line_start, frame_start, pix_r, pix_g, pix_b}),
            32'(17'b1_0_000_0000_0000_0000));
        chk("rst_req", 32'({req_valid, curr_x, curr_y}), 32'(0));
        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        qh.delete();
        qv.delete();
        for (int i = 0; i < P + 1; i++) begin
            qh.push_back(NOPE);
            qv.push_back(NOPE);
        end
        m_hc   = 0;
        m_vc   = 0;
        last_o = model_out(NOPE, NOPE, 2'd0);
        last_q = '0;
    endtask

    initial begin
        int  n;
        bit  found;

        sp[0]  = '{2'd1, 0, 0, 12'h000};
        sp[1]  = '{2'd1, 7, 3, 12'h000};
        sp[2]  = '{2'd1, 8, 0, 12'hF00};
        sp[3]  = '{2'd1, 15, 2, 12'hF00};
        sp[4]  = '{2'd1, 16, 5, 12'h0F0};
        sp[5]  = '{2'd1, 24, 0, 12'hFF0};
        sp[6]  = '{2'd1, 32, 1, 12'h00F};
        sp[7]  = '{2'd1, 40, 0, 12'hF0F};
        sp[8]  = '{2'd1, 56, 0, 12'hFFF};
        sp[9]  = '{2'd1, 63, 39, 12'hFFF};
        sp[10] = '{2'd2, 32, 0, 12'hFFF};
        sp[11] = '{2'd2, 32, 32, 12'h000};
        sp[12] = '{2'd2, 0, 32, 12'hFFF};
        sp[13] = '{2'd2, 31, 31, 12'h000};
        sp[14] = '{2'd0, 3, 4, 12'h347};
        sp[15] = '{2'd0, 20, 1, 12'h415};

        ph[0] = '{1'b1, 2'd1, FRAME};
        ph[1] = '{1'b1, 2'd2, FRAME};
        ph[2] = '{1'b1, 2'd3, 150};
        ph[3] = '{1'b1, 2'd0, 37};
        ph[4] = '{1'b0, 2'd0, 100};
        ph[5] = '{1'b1, 2'd0, 300};
        ph[6] = '{1'b1, 2'd1, 500};

        apply_reset();
        fs_cnt = 0;
        ls_cnt = 0;
        de_cnt = 0;
        repeat (2 * FRAME) step(1'b1, 2'd0);
        chk("frame_starts_2frames", 32'(fs_cnt), 32'(2));
        chk("line_starts_2frames", 32'(ls_cnt), 32'(2 * VA));
        chk("de_cycles_2frames", 32'(de_cnt), 32'(2 * VA * HA));

        for (int i = 0; i < 7; i++) begin
            repeat (ph[i].n) step(ph[i].en, ph[i].md);
        end

        apply_reset();
        n = 0;
        found = 1'b0;
        while (!found && n < 2 * FRAME) begin
            step(1'b1, 2'd0);
            n++;
            if (frame_start) found = 1'b1;
        end
        chk("first_fs_latency", 32'(n), 32'(VS * HT + HS + P + 2));
        fs_cnt = 0;
        repeat (FRAME) step(1'b1, 2'd0);
        chk("fs_per_frame", 32'(fs_cnt), 32'(1));

        for (int i = 0; i < 16; i++) chk("spot_visited", 32'(hit[i]), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
